// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-32 controller: states, opcodes,
// datapath mux selects and the control-word layout.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J
  } op_class_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic       regDst;
  } ctrl_t;

  function automatic op_class_e classifyOp(input logic [5:0] op);
    case (op)
      OP_RTYPE: classifyOp = CLS_RTYPE;
      OP_ADDI:  classifyOp = CLS_ADDI;
      OP_LW:    classifyOp = CLS_LW;
      OP_SW:    classifyOp = CLS_SW;
      OP_BEQ:   classifyOp = CLS_BEQ;
      OP_J:     classifyOp = CLS_J;
      default:  classifyOp = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore control-word decode from the controller state; only the FETCH
// instruction/PC loads look at MemReady.
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcSource = PCSRC_ALU;
        ctrl_o.irWrite  = mem_ready_i;
        ctrl_o.pcWrite  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB = SRCB_IMM_SHL2;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memToReg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_B;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.regDst   = 1'b1;
      end
      S_ADDI_WB: ctrl_o.regWrite = 1'b1;
      S_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluSrcB     = SRCB_B;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-32 control FSM with memory-ready stalls. Defining
// PERF_CNT_EN adds the InstrRetired counter port.
module multicycle_controller
  import mips_mc_pkg::*;
`ifdef PERF_CNT_EN
  #(parameter int unsigned CNT_WIDTH = 32)
`endif
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] State,
`ifdef PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] InstrRetired,
`endif
  output logic       IllegalOp
);

  state_e    state_q, state_d;
  op_class_e opClass_q, opClass_d;
  op_class_e decClass;
  ctrl_t     ctrl;

  assign decClass = classifyOp(OpCode);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      opClass_q <= CLS_NONE;
    end else begin
      state_q   <= state_d;
      opClass_q <= opClass_d;
    end
  end

  // MEM_ADDR picks lw/sw from the class latched in DECODE, not the live opcode.
  always_comb begin
    state_d   = state_q;
    opClass_d = opClass_q;
    IllegalOp = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        opClass_d = decClass;
        case (decClass)
          CLS_RTYPE:     state_d = S_EXECUTE;
          CLS_ADDI:      state_d = S_ADDI_EXEC;
          CLS_LW, CLS_SW: state_d = S_MEM_ADDR;
          CLS_BEQ:       state_d = S_BRANCH;
          CLS_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            IllegalOp = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opClass_q == CLS_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (MemReady) state_d = S_MEM_WB;
      S_MEM_WRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decode uDecode (
    .state_i     (state_q),
    .mem_ready_i (MemReady),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign IRWrite     = ctrl.irWrite;
  assign MemToReg    = ctrl.memToReg;
  assign PCSource    = ctrl.pcSource;
  assign ALUOp       = ctrl.aluOp;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign RegWrite    = ctrl.regWrite;
  assign RegDst      = ctrl.regDst;
  assign State       = state_q;

`ifdef PERF_CNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] retired_q;

  // An instruction retires on the edge leaving its final state.
  assign retire = (state_q inside {S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP})
                || (state_q == S_MEM_WRITE && MemReady);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  assign InstrRetired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; optional
// InstrRetired checks follow PERF_CNT_EN.
module tb_multicycle_controller;

   logic       Clk;
   logic       Reset_n;
   logic [5:0] OpCode;
   logic       MemReady;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemToReg, ALUSrcA, RegWrite, RegDst, IllegalOp;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic [3:0] State;
`ifdef PERF_CNT_EN
   logic [31:0] instrRetired;
`endif

   int compareCount = 0;
   int errorCount   = 0;

   multicycle_controller dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .OpCode      (OpCode),
      .MemReady    (MemReady),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemToReg    (MemToReg),
      .PCSource    (PCSource),
      .ALUOp       (ALUOp),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .State       (State),
`ifdef PERF_CNT_EN
      .InstrRetired(instrRetired),
`endif
      .IllegalOp   (IllegalOp)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Flatten the control outputs so a whole state's word can be compared at once.
   function automatic logic [15:0] obsWord();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
              PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};
   endfunction

   // Hand-built expected control word for each state, straight from the state table.
   function automatic logic [15:0] expectedWord(input logic [3:0] st, input logic mr);
      logic pcW, pcWC, iord, mRd, mWr, irW, m2r, srcA, rW, rDst;
      logic [1:0] pcSrc, aOp, srcB;
      {pcW, pcWC, iord, mRd, mWr, irW, m2r, srcA, rW, rDst} = '0;
      pcSrc = 2'b00; aOp = 2'b00; srcB = 2'b00;
      case (st)
         4'd1:  begin mRd = 1'b1; srcB = 2'b01; irW = mr; pcW = mr; end
         4'd2:  srcB = 2'b11;
         4'd3:  begin srcA = 1'b1; srcB = 2'b10; end
         4'd4:  begin mRd = 1'b1; iord = 1'b1; end
         4'd5:  begin rW = 1'b1; m2r = 1'b1; end
         4'd6:  begin mWr = 1'b1; iord = 1'b1; end
         4'd7:  begin srcA = 1'b1; aOp = 2'b10; end
         4'd8:  begin rW = 1'b1; rDst = 1'b1; end
         4'd9:  begin srcA = 1'b1; srcB = 2'b10; end
         4'd10: rW = 1'b1;
         4'd11: begin srcA = 1'b1; aOp = 2'b01; pcWC = 1'b1; pcSrc = 2'b01; end
         4'd12: begin pcW = 1'b1; pcSrc = 2'b10; end
         default: ;
      endcase
      return {pcW, pcWC, iord, mRd, mWr, irW, m2r, pcSrc, aOp, srcA, srcB, rW, rDst};
   endfunction

   function automatic logic isIllegal(input logic [5:0] op);
      return !(op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010});
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Runs one instruction starting in FETCH (#1 after an edge); seq holds one
   // expected state per nibble, mr holds MemReady per cycle, bit 0 first.
   task automatic applyStimulus(input string name, input logic [5:0] op, input int nCycles,
                                input logic [31:0] seq, input logic [7:0] mr);
      logic [3:0] expSt;
      for (int i = 0; i < nCycles; i++) begin
         OpCode   = op;
         MemReady = mr[i];
         #1;
         expSt = seq[i*4 +: 4];
         checkOutput($sformatf("%s state c%0d", name, i), {28'd0, State}, {28'd0, expSt});
         checkOutput($sformatf("%s ctrl c%0d", name, i), {16'd0, obsWord()},
                     {16'd0, expectedWord(expSt, mr[i])});
         checkOutput($sformatf("%s illegal c%0d", name, i), {31'd0, IllegalOp},
                     {31'd0, (expSt == 4'd2) && isIllegal(op)});
         @(posedge Clk); #1;
      end
      MemReady = 1'b1;
      #1;
      checkOutput($sformatf("%s back to FETCH", name), {28'd0, State}, 32'd1);
      #1;
   endtask

   initial begin
      Reset_n  = 1'b1;
      OpCode   = 6'd0;
      MemReady = 1'b0;
      #1 Reset_n = 1'b0;
      #12;
      checkOutput("reset state", {28'd0, State}, 32'd0);
      checkOutput("reset ctrl", {16'd0, obsWord()}, 32'd0);
      checkOutput("reset illegal", {31'd0, IllegalOp}, 32'd0);
`ifdef PERF_CNT_EN
      checkOutput("reset counter", instrRetired, 32'd0);
`endif
      @(negedge Clk) Reset_n = 1'b1;
      @(posedge Clk); #1;
      checkOutput("fetch after release", {28'd0, State}, 32'd1);

      applyStimulus("rtype", 6'b000000, 4, 32'h0000_8721, 8'hFF);
      applyStimulus("lw",    6'b100011, 8, 32'h5444_4321, 8'b1100_0111);
      applyStimulus("sw",    6'b101011, 6, 32'h0066_3211, 8'b0010_1110);
      applyStimulus("beq",   6'b000100, 3, 32'h0000_0B21, 8'hFF);
      applyStimulus("j",     6'b000010, 3, 32'h0000_0C21, 8'hFF);
      applyStimulus("illegal", 6'b111111, 2, 32'h0000_0021, 8'hFF);
`ifdef PERF_CNT_EN
      checkOutput("retired after five", instrRetired, 32'd5);
`endif
      applyStimulus("addi",  6'b001000, 4, 32'h0000_A921, 8'hFF);
`ifdef PERF_CNT_EN
      checkOutput("retired after addi", instrRetired, 32'd6);
`endif

      // Walk an sw into MEM_WRITE, stall there, then pull reset mid-access.
      OpCode   = 6'b101011;
      MemReady = 1'b1;
      repeat (3) begin
         @(posedge Clk); #1;
      end
      MemReady = 1'b0;
      #1;
      checkOutput("abort pre state", {28'd0, State}, 32'd6);
      checkOutput("abort pre memwrite", {31'd0, MemWrite}, 32'd1);
      Reset_n = 1'b0;
      #1;
      checkOutput("abort memwrite", {31'd0, MemWrite}, 32'd0);
      checkOutput("abort state", {28'd0, State}, 32'd0);
      checkOutput("abort ctrl", {16'd0, obsWord()}, 32'd0);
`ifdef PERF_CNT_EN
      checkOutput("abort counter", instrRetired, 32'd0);
`endif
      @(negedge Clk) Reset_n = 1'b1;
      #1;
      checkOutput("idle before edge", {28'd0, State}, 32'd0);
      @(posedge Clk); #1;
      checkOutput("fetch after abort", {28'd0, State}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multi-cycle MIPS-32 datapath. It sequences one shared memory, one ALU and the PC/IR/register-file write enables over several cycles per instruction. It covers R-type, addi, lw, sw, beq and j. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter (only used with PERF_CNT_EN).

Ports:
Clk  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous, active-low reset
OpCode  input  6  Instruction[31:26] from IR; valid from DECODE onward
MemReady  input  1  memory has completed the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU Zero (beq)
IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemToReg  output  1  register write data: 1 = MDR, 0 = ALUOut
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
RegWrite  output  1  register file write enable
RegDst  output  1  1 = rd, 0 = rt
State  output  4  current state encoding, for debug and bench use
IllegalOp  output  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Moore outputs are decoded from the state register. The only exceptions are IRWrite and PCWrite in FETCH, which are gated by MemReady.
- States and encodings:
  - IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6
  - EXECUTE 7, R_WB 8, ADDI_EXEC 9, ADDI_WB 10, BRANCH 11, JUMP 12
  - Codes 13-15 are unused and must go to FETCH on the next edge.
- Reset: while Reset_n = 0, State = IDLE and every output is 0. This is asynchronous: outputs drop within the same cycle. A reset mid-access aborts the access with no write-enable asserted. IDLE goes to FETCH on the first clock edge after release.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Latches the opcode class into an internal register; later dispatches use the latched class.
  - Next state by opcode:
    - 000000 goes to EXECUTE.
    - 001000 goes to ADDI_EXEC.
    - 100011 and 101011 go to MEM_ADDR.
    - 000100 goes to BRANCH.
    - 000010 goes to JUMP.
    - Any other opcode goes to FETCH with IllegalOp=1 for that cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady=1, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0. Goes to FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- Any output not listed for a state is 0.
- Latency with zero wait states (FETCH to next FETCH): R-type 4, addi 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each MemReady=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in the same cycle as MemWrite.

Optional Feature:
PERF_CNT_EN:
- When defined, adds output port InstrRetired [CNT_WIDTH-1:0].
  - Resets to 0.
  - Increments by 1 on the edge leaving MEM_WB, MEM_WRITE (with MemReady=1), R_WB, ADDI_WB, BRANCH or JUMP.
  - Illegal opcodes do not count.
  - Wraps modulo 2^CNT_WIDTH.
- When not defined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mips_mc_pkg holds:
  - state encoding localparams;
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - ALUOp, PCSource and ALUSrcB encodings.
- One combinational sub-module, mc_output_decode (state plus MemReady to control word), keeps the next-state logic separate from the output decode.

Test Plan:
- Reset_n=0 mid-MEM_WRITE with MemWrite=1 -> same cycle MemWrite=0 and State=0; first edge after release -> State=1.
- OpCode=000000, MemReady=1 constant -> State sequence 1,2,7,8,1; RegWrite=1 and RegDst=1 only in state 8.
- OpCode=100011, MemReady low 3 cycles in MEM_READ -> 8 cycles FETCH to FETCH; MemToReg=1 only in state 5.
- OpCode=101011 -> MemWrite=1 and IorD=1 in state 6; RegWrite stays 0 throughout.
- OpCode=000100, then 000010 -> beq: PCWriteCond=1, PCSource=01, ALUOp=01 in state 11; j: PCWrite=1, PCSource=10 in state 12; each 3 cycles.
- OpCode=111111 -> IllegalOp=1 for one cycle in DECODE, back to FETCH, no write enables asserted. With PERF_CNT_EN, InstrRetired is unchanged after the illegal opcode and equals 5 after the five legal instructions above.
